// File: rtl/mask_centroid.sv
// mask_centroid: per-frame mask statistics with a sequential restoring
// divider that publishes centroid and bounding box at vertical sync.
module mask_centroid #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int MIN_PIXELS   = 64,
  localparam int XW = $clog2(LINE_WIDTH),
  localparam int YW = $clog2(FRAME_HEIGHT),
  localparam int CW = $clog2(LINE_WIDTH * FRAME_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  input  logic          vs_ni,
  input  logic          hs_ni,
  input  logic          blank_ni,
  input  logic          mask_i,
  output logic [XW-1:0] centroid_x_o,
  output logic [YW-1:0] centroid_y_o,
  output logic [XW-1:0] min_x_o,
  output logic [XW-1:0] max_x_o,
  output logic [YW-1:0] min_y_o,
  output logic [YW-1:0] max_y_o,
  output logic [CW-1:0] pixel_count_o,
  output logic          obj_found_o,
  output logic          result_valid_o,
  output logic          busy_o
);

  localparam int SXW = XW + CW;
  localparam int SYW = YW + CW;
  localparam int NW  = (SXW > SYW) ? SXW : SYW;
  localparam int SW  = $clog2(NW + 1);
  localparam logic [XW-1:0] XMAX  = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] YMAX  = YW'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0] MINC  = CW'(MIN_PIXELS);
  localparam logic [SW-1:0] XLAST = SW'(SXW - 1);
  localparam logic [SW-1:0] YLAST = SW'(SYW - 1);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} state_t;

  logic unused_hs;
  assign unused_hs = hs_ni;

  logic           vs_prev_q, act_prev_q;
  logic [XW-1:0]  x_q, x_d, xc;
  logic [YW-1:0]  y_q, y_d, yc;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SXW-1:0] sx_q, sx_d;
  logic [SYW-1:0] sy_q, sy_d;
  logic [XW-1:0]  minx_q, minx_d, maxx_q, maxx_d;
  logic [YW-1:0]  miny_q, miny_d, maxy_q, maxy_d;

  logic fe, act, le, hit;
  assign fe  = en_i & vs_prev_q & ~vs_ni;
  assign act = en_i & blank_ni;
  assign le  = en_i & act_prev_q & ~blank_ni;
  assign hit = act & mask_i;
  // A pixel sampled on the frame-end edge already belongs to the new frame
  assign xc  = fe ? '0 : x_q;
  assign yc  = fe ? '0 : y_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cnt_d  = cnt_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    minx_d = minx_q;
    maxx_d = maxx_q;
    miny_d = miny_q;
    maxy_d = maxy_q;
    if (fe) begin
      x_d    = '0;
      y_d    = '0;
      cnt_d  = '0;
      sx_d   = '0;
      sy_d   = '0;
      minx_d = '1;
      maxx_d = '0;
      miny_d = '1;
      maxy_d = '0;
    end
    if (act) begin
      x_d = (xc == XMAX) ? xc : xc + 1'b1;
    end else if (le && !fe) begin
      x_d = '0;
      y_d = (y_q == YMAX) ? y_q : y_q + 1'b1;
    end
    if (hit) begin
      cnt_d = cnt_d + 1'b1;
      sx_d  = sx_d + SXW'(xc);
      sy_d  = sy_d + SYW'(yc);
      if (xc < minx_d) minx_d = xc;
      if (xc > maxx_d) maxx_d = xc;
      if (yc < miny_d) miny_d = yc;
      if (yc > maxy_d) maxy_d = yc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q  <= 1'b1;
      act_prev_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      minx_q     <= '1;
      maxx_q     <= '0;
      miny_q     <= '1;
      maxy_q     <= '0;
    end else begin
      if (en_i) begin
        vs_prev_q  <= vs_ni;
        act_prev_q <= blank_ni;
      end
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      minx_q <= minx_d;
      maxx_q <= maxx_d;
      miny_q <= miny_d;
      maxy_q <= maxy_d;
    end
  end

  state_t         state_q;
  logic [SW-1:0]  step_q;
  logic [NW-1:0]  num_q;
  logic [CW-1:0]  rem_q;
  logic [CW-1:0]  cnt_s_q;
  logic [SYW-1:0] sy_s_q;
  logic [XW-1:0]  bminx_q, bmaxx_q, qx_q;
  logic [YW-1:0]  bminy_q, bmaxy_q, qy_q;
  logic [XW-1:0]  cx_q, ominx_q, omaxx_q;
  logic [YW-1:0]  cy_q, ominy_q, omaxy_q;
  logic [CW-1:0]  ocnt_q;
  logic           found_q, valid_q;

  // Restoring step: quotient bits shift in at the LSB of num_q
  logic [CW:0]   trial, diff;
  logic          ge;
  logic [CW-1:0] rem_nx;
  logic [NW-1:0] num_nx;
  assign trial  = {rem_q, num_q[NW-1]};
  assign diff   = trial - {1'b0, cnt_s_q};
  assign ge     = (trial >= {1'b0, cnt_s_q});
  assign rem_nx = ge ? diff[CW-1:0] : trial[CW-1:0];
  assign num_nx = {num_q[NW-2:0], ge};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_s_q <= '0;
      sy_s_q  <= '0;
      bminx_q <= '0;
      bmaxx_q <= '0;
      bminy_q <= '0;
      bmaxy_q <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ominx_q <= '0;
      omaxx_q <= '0;
      ominy_q <= '0;
      omaxy_q <= '0;
      ocnt_q  <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (fe) begin
        cnt_s_q <= cnt_q;
        sy_s_q  <= sy_q;
        bminx_q <= minx_q;
        bmaxx_q <= maxx_q;
        bminy_q <= miny_q;
        bmaxy_q <= maxy_q;
        num_q   <= NW'(sx_q) << (NW - SXW);
        rem_q   <= '0;
        step_q  <= '0;
        state_q <= (cnt_q != '0) ? DIV_X : PUBLISH;
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          DIV_X: begin
            rem_q <= rem_nx;
            if (step_q == XLAST) begin
              qx_q    <= num_nx[XW-1:0];
              num_q   <= NW'(sy_s_q) << (NW - SYW);
              rem_q   <= '0;
              step_q  <= '0;
              state_q <= DIV_Y;
            end else begin
              num_q  <= num_nx;
              step_q <= step_q + 1'b1;
            end
          end
          DIV_Y: begin
            rem_q  <= rem_nx;
            num_q  <= num_nx;
            step_q <= step_q + 1'b1;
            if (step_q == YLAST) begin
              qy_q    <= num_nx[YW-1:0];
              state_q <= PUBLISH;
            end
          end
          PUBLISH: begin
            valid_q <= 1'b1;
            state_q <= IDLE;
            if (cnt_s_q == '0) begin
              cx_q    <= '0;
              cy_q    <= '0;
              ominx_q <= '0;
              omaxx_q <= '0;
              ominy_q <= '0;
              omaxy_q <= '0;
              ocnt_q  <= '0;
              found_q <= 1'b0;
            end else begin
              cx_q    <= qx_q;
              cy_q    <= qy_q;
              ominx_q <= bminx_q;
              omaxx_q <= bmaxx_q;
              ominy_q <= bminy_q;
              omaxy_q <= bmaxy_q;
              ocnt_q  <= cnt_s_q;
              found_q <= (cnt_s_q >= MINC);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign centroid_x_o   = cx_q;
  assign centroid_y_o   = cy_q;
  assign min_x_o        = ominx_q;
  assign max_x_o        = omaxx_q;
  assign min_y_o        = ominy_q;
  assign max_y_o        = omaxy_q;
  assign pixel_count_o  = ocnt_q;
  assign obj_found_o    = found_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q != IDLE);

endmodule
